// File: rtl/elink_frame_tx.sv
// elink_frame_tx: HDLC-style frame transmitter for the 2-bit elink path.
// Takes a byte stream (valid/ready/last) and builds frames: opening flag,
// escape-stuffed payload, optional stuffed CRC-8, closing flag. Each line
// byte is sent as four dibits, MSB first. Flags are sent while idle.
`timescale 1ns/1ps
module elink_frame_tx #(
    parameter logic [7:0] FLAG_BYTE = 8'h7E,
    parameter logic [7:0] ESC_BYTE  = 8'h7D,
    parameter bit         CRC_EN    = 1'b1,
    parameter int         CNT_WIDTH = 16
) (
    input  logic                 clk40,
    input  logic                 reset,
    input  logic [7:0]           data_in,
    input  logic                 data_valid,
    input  logic                 data_last,
    output logic                 data_ready,
    output logic [1:0]           tx_elink2bit,
    output logic                 busy,
    output logic                 underrun,
    output logic [CNT_WIDTH-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_DATA, S_ESC, S_CRC, S_CRC_ESC, S_EOF, S_DROP
    } state_t;

    state_t               state_reg;
    logic [1:0]           phase_reg;
    logic [7:0]           shreg_reg;
    logic [7:0]           hold_reg;
    logic [7:0]           crc_reg;
    logic                 hold_last_reg;
    logic                 esc_pending_reg;
    logic                 last_seen_reg;
    logic                 busy_reg;
    logic                 busy_clr_reg;
    logic                 underrun_reg;
    logic [1:0]           tx_reg;
    logic [CNT_WIDTH-1:0] frame_cnt_reg;

    logic   accept;
    logic   data_special;
    logic   crc_special;
    state_t after_last;

    // CRC-8, poly 0x07, MSB first, one byte per call
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Ready is a pure function of registered state: once per byte slot in DATA,
    // every cycle while draining an aborted frame in DROP.
    assign data_ready   = ((state_reg == S_DATA) && (phase_reg == 2'd3) && !esc_pending_reg)
                          || (state_reg == S_DROP);
    assign accept       = data_valid & data_ready;
    assign data_special = (data_in == FLAG_BYTE) || (data_in == ESC_BYTE);
    assign crc_special  = (crc_reg == FLAG_BYTE) || (crc_reg == ESC_BYTE);
    assign after_last   = CRC_EN ? S_CRC : S_EOF;

    assign tx_elink2bit = tx_reg;
    assign busy         = busy_reg;
    assign underrun     = underrun_reg;
    assign frame_cnt    = frame_cnt_reg;

    // Dibit shifter, byte-slot framing FSM and status registers
    always_ff @(posedge clk40) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            phase_reg       <= 2'd0;
            shreg_reg       <= FLAG_BYTE;
            hold_reg        <= 8'h00;
            crc_reg         <= 8'h00;
            hold_last_reg   <= 1'b0;
            esc_pending_reg <= 1'b0;
            last_seen_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            busy_clr_reg    <= 1'b0;
            underrun_reg    <= 1'b0;
            tx_reg          <= 2'b00;
            frame_cnt_reg   <= '0;
        end else begin
            phase_reg    <= phase_reg + 2'd1;
            tx_reg       <= shreg_reg[7:6];
            shreg_reg    <= {shreg_reg[5:0], 2'b00};
            underrun_reg <= 1'b0;

            // busy falls once the closing flag's last dibit has left the line
            if (busy_clr_reg && (phase_reg == 2'd0)) begin
                busy_reg     <= 1'b0;
                busy_clr_reg <= 1'b0;
            end

            if (phase_reg == 2'd3) begin
                case (state_reg)
                    S_IDLE: begin
                        shreg_reg <= FLAG_BYTE;
                        if (data_valid) begin
                            state_reg     <= S_DATA;
                            busy_reg      <= 1'b1;
                            busy_clr_reg  <= 1'b0;
                            crc_reg       <= 8'h00;
                            last_seen_reg <= 1'b0;
                        end else if (busy_reg) begin
                            busy_clr_reg <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (accept) begin
                            crc_reg       <= crc8_next(crc_reg, data_in);
                            last_seen_reg <= data_last;
                            if (data_special) begin
                                shreg_reg       <= ESC_BYTE;
                                hold_reg        <= data_in ^ 8'h20;
                                hold_last_reg   <= data_last;
                                esc_pending_reg <= 1'b1;
                                state_reg       <= S_ESC;
                            end else begin
                                shreg_reg <= data_in;
                                if (data_last) begin
                                    state_reg <= after_last;
                                end
                            end
                        end else if (!data_valid) begin
                            // Source ran dry mid-frame: close with a bare flag
                            shreg_reg    <= FLAG_BYTE;
                            underrun_reg <= 1'b1;
                            state_reg    <= last_seen_reg ? S_IDLE : S_DROP;
                        end
                    end
                    S_ESC: begin
                        shreg_reg       <= hold_reg;
                        esc_pending_reg <= 1'b0;
                        state_reg       <= hold_last_reg ? after_last : S_DATA;
                    end
                    S_CRC: begin
                        if (crc_special) begin
                            shreg_reg <= ESC_BYTE;
                            hold_reg  <= crc_reg ^ 8'h20;
                            state_reg <= S_CRC_ESC;
                        end else begin
                            shreg_reg <= crc_reg;
                            state_reg <= S_EOF;
                        end
                    end
                    S_CRC_ESC: begin
                        shreg_reg <= hold_reg;
                        state_reg <= S_EOF;
                    end
                    S_EOF: begin
                        shreg_reg     <= FLAG_BYTE;
                        frame_cnt_reg <= frame_cnt_reg + CNT_WIDTH'(1);
                        crc_reg       <= 8'h00;
                        state_reg     <= S_IDLE;
                    end
                    S_DROP: begin
                        shreg_reg <= FLAG_BYTE;
                    end
                    default: begin
                        shreg_reg <= FLAG_BYTE;
                        state_reg <= S_IDLE;
                    end
                endcase
            end

            // Drain of an aborted frame ends on any cycle with the last byte
            if ((state_reg == S_DROP) && accept && data_last) begin
                state_reg    <= S_IDLE;
                busy_reg     <= 1'b0;
                busy_clr_reg <= 1'b0;
            end
        end
    end

endmodule

// File: doc/elink_frame_tx.md
Name: elink_frame_tx

Overview:
Frame transmitter for the 2-bit elink path at 40 MHz (80 Mb/s). Takes a byte stream with valid/ready/last and builds HDLC-style frames: opening flag, escape-stuffed payload, optional CRC-8, closing flag. Sends each byte as four dibits, MSB first, on the 2-bit parallel bus that feeds the 80 MHz 2-to-1 elink serializer. Sends continuous flag bytes when idle.

Parameters:
FLAG_BYTE, 8'h7E, frame delimiter and idle fill byte
ESC_BYTE, 8'h7D, escape byte; the escaped byte is sent as (byte ^ 8'h20)
CRC_EN, 1, 1 appends a stuffed CRC-8 (poly 0x07, init 0x00, MSB first, over unstuffed payload); 0 omits it
CNT_WIDTH, 16, width of the sent-frame counter

Ports:
clk40  in  1  40 MHz clock, only clock of the block
reset  in  1  synchronous, active-high reset
data_in  in  8  payload byte
data_valid  in  1  data_in/data_last valid
data_last  in  1  marks final payload byte of frame
data_ready  out  1  byte accepted when data_valid & data_ready
tx_elink2bit  out  2  dibit to serializer, registered
busy  out  1  high from frame start decision to end of closing flag
underrun  out  1  one-cycle pulse on payload underrun
frame_cnt  out  CNT_WIDTH  frames closed normally (excludes aborted), wraps

Behaviour:
- Reset (synchronous): state=IDLE, phase=0, shift register=FLAG_BYTE, tx_elink2bit=2'b00, data_ready=0, busy=0, underrun=0, frame_cnt=0, crc=0, esc_pending=0.
- Reset mid-frame abandons the frame at once. It does not count the frame and does not pulse underrun.
- 2-bit phase counter, 0..3, free-running. tx_elink2bit <= shreg[7:6] each cycle, then shreg shifts left 2. On phase==3 the next byte is loaded, so the byte boundary is fixed at 4 cycles.
- Latency: a byte loaded at phase 3 of cycle N appears on tx_elink2bit in cycles N+2..N+5, in the order [7:6],[5:4],[3:2],[1:0].
- States: IDLE, DATA, ESC, CRC, CRC_ESC, EOF, DROP. All transitions are evaluated at phase==3 except DROP.
- IDLE: load FLAG_BYTE.
  - data_valid=1 at phase 3: go to DATA and set busy=1. The loaded flag is the opening flag.
  - data_valid is not consumed in IDLE.
- DATA: data_ready=1 only at phase==3 with esc_pending=0.
  - On accept, update crc with the raw byte.
  - Byte equal to FLAG_BYTE or ESC_BYTE: load ESC_BYTE, go to ESC, hold byte^8'h20. Otherwise load the byte.
  - Accepted byte with data_last=1: next state is CRC when CRC_EN=1, else EOF. The move happens after any pending ESC.
  - data_valid=0 at phase 3 (underrun): load FLAG_BYTE (abort close), pulse underrun, no frame_cnt increment.
    - Go to DROP if the last byte has not been seen, else IDLE.
- ESC: load the held byte, then return to DATA (or to CRC/EOF if that byte was last). data_ready=0.
- CRC: load the crc, or ESC_BYTE then the escaped crc through CRC_ESC.
- EOF: load FLAG_BYTE, frame_cnt+1 (wraps), crc cleared, go to IDLE. busy drops after the flag's last dibit.
  - A new frame needs an IDLE phase-3 decision, so there are two flags between back-to-back frames.
- DROP: data_ready=1 every cycle and accepted bytes are discarded. data_last accepted -> IDLE.
  - Output keeps sending flags. busy stays 1 until leaving DROP.
- Empty frame is not possible: the first accepted byte always carries payload.

Test Plan:
- Idle after reset, no data_valid -> tx_elink2bit repeats 01,11,11,10 from the 2nd cycle; data_ready=0, busy=0.
- CRC_EN=1, single byte 8'h41 with last -> byte stream 7E 7E 41 C0 7E 7E; dibits of 41 = 01,00,00,01 and of C0 = 11,00,00,00; frame_cnt=1.
- Payload 8'h7E,8'h7D,8'h10 (last) -> 7D 5E 7D 5D 10 crc 7E; data_ready low during each ESC byte slot.
- Source drops data_valid after the 2nd of 5 bytes -> flag sent at the next slot, one-cycle underrun, frame_cnt unchanged; the remaining 3 bytes are consumed in DROP and do not appear on the line.
- Assert reset while the 2nd payload byte is on the line -> next cycle tx_elink2bit=00, state IDLE, flags resume, frame_cnt unchanged.
- CNT_WIDTH=2, send 5 frames -> frame_cnt goes 1,2,3,0,1.
